// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the instruction/data RAM arbiter: lane masks, grant
// encoding and small lane helpers.
package mem_arbiter_pkg;

  localparam logic [3:0] LANE_B = 4'b0001;
  localparam logic [3:0] LANE_H = 4'b0011;
  localparam logic [3:0] LANE_W = 4'b1111;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_D    = 2'd1,
    GNT_I    = 2'd2,
    GNT_IP   = 2'd3
  } gnt_e;

  // True when shifting the lane mask up by the byte offset spills past lane 3.
  function automatic logic lane_overflow(input logic [3:0] mask, input logic [1:0] off);
    logic [6:0] wide;
    wide = {3'b000, mask} << off;
    return |wide[6:4];
  endfunction

  // Bits of a right-justified load that carry data; the rest are zeroed.
  function automatic logic [31:0] lane_bits(input logic [3:0] mask);
    case (mask)
      LANE_B:  return 32'h0000_00FF;
      LANE_H:  return 32'h0000_FFFF;
      LANE_W:  return 32'hFFFF_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_lane_align.sv
// Byte-lane shifter: moves a word up (store) or down (load) by whole bytes.
module lane_align #(
  parameter bit SHIFT_LEFT = 1'b1
) (
  input  logic [31:0] data_in,
  input  logic [1:0]  off,
  output logic [31:0] data_out
);

  logic [4:0] shamt;

  always_comb begin
    shamt = {off, 3'b000};
    if (SHIFT_LEFT) data_out = data_in << shamt;
    else            data_out = data_in >> shamt;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between fetch and data ports, data first.
// Optional fetch starvation guard: define MEMARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       imem_addr,
  input  logic              imem_oe,
  output logic [31:0]       imem_rdata,
  output logic              imem_valid,
  input  logic [31:0]       mem_addr,
  input  logic [3:0]        mem_oe,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_we,
  output logic [31:0]       mem_rdata,
  output logic              mem_valid,
  output logic              mem_ready,
  output logic [ADDR_W-3:0] ram_addr,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              misalign
);

  gnt_e              gnt;
  logic              data_req;
  logic              store;
  logic [1:0]        off;
  logic [3:0]        we_sh;
  logic              ipend_v;
  logic [ADDR_W-3:0] ipend_addr;
  logic              rd_i;
  logic              rd_d;
  logic [1:0]        off_q;
  logic [3:0]        oe_q;
  logic [31:0]       ihold;
  logic [31:0]       dhold;
  logic [31:0]       st_data;
  logic [31:0]       ld_data;
  logic [31:0]       ld_masked;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{mem_addr[31:ADDR_W], imem_addr[1:0]};

  assign data_req = |mem_oe;
  assign store    = |mem_we;
  assign off      = mem_addr[1:0];
  assign we_sh    = mem_we << off;

  lane_align #(.SHIFT_LEFT(1'b1)) u_store_align (
    .data_in  (mem_wdata),
    .off      (off),
    .data_out (st_data)
  );

  lane_align #(.SHIFT_LEFT(1'b0)) u_load_align (
    .data_in  (ram_rdata),
    .off      (off_q),
    .data_out (ld_data)
  );

  // A new fetch beats a parked one: it carries the post-branch address.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst) begin
      if (data_req)     gnt = GNT_D;
      else if (imem_oe) gnt = GNT_I;
      else if (ipend_v) gnt = GNT_IP;
    end
  end

  always_comb begin
    ram_addr = '0;
    case (gnt)
      GNT_D:   ram_addr = mem_addr[ADDR_W-1:2];
      GNT_I:   ram_addr = imem_addr[ADDR_W-1:2];
      GNT_IP:  ram_addr = ipend_addr;
      default: ram_addr = '0;
    endcase
  end

  assign ram_en    = (gnt != GNT_NONE);
  assign ram_we    = (gnt == GNT_D) ? we_sh : 4'b0000;
  assign ram_wdata = st_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      ipend_v    <= 1'b0;
      ipend_addr <= '0;
    end else if (data_req && imem_oe) begin
      ipend_v    <= 1'b1;
      ipend_addr <= imem_addr[ADDR_W-1:2];
    end else if (gnt == GNT_I || gnt == GNT_IP) begin
      ipend_v    <= 1'b0;
    end
  end

  assign ld_masked = ld_data & lane_bits(oe_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_i     <= 1'b0;
      rd_d     <= 1'b0;
      off_q    <= 2'b00;
      oe_q     <= 4'b0000;
      ihold    <= '0;
      dhold    <= '0;
      misalign <= 1'b0;
    end else begin
      rd_i <= (gnt == GNT_I) || (gnt == GNT_IP);
      rd_d <= (gnt == GNT_D) && !store;
      if (gnt == GNT_D) begin
        off_q <= off;
        oe_q  <= mem_oe;
        if (lane_overflow(mem_oe, off)) misalign <= 1'b1;
      end
      if (rd_i) ihold <= ram_rdata;
      if (rd_d) dhold <= ld_masked;
    end
  end

  // Returns in flight when reset arrives are suppressed, not delivered.
  assign imem_valid = rd_i && !rst;
  assign mem_valid  = rd_d && !rst;
  assign imem_rdata = rst ? '0 : (rd_i ? ram_rdata : ihold);
  assign mem_rdata  = rst ? '0 : (rd_d ? ld_masked : dhold);

`ifdef MEMARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt <= '0;
    else if (!ipend_v || gnt == GNT_IP || gnt == GNT_I)
      starve_cnt <= '0;
    else
      starve_cnt <= starve_cnt + 1'b1;
  end

  // One ready-low cycle guarantees a data-free cycle for the parked fetch.
  assign mem_ready = !rst && !(ipend_v && starve_cnt == CNT_W'(STARVE_LIMIT - 1));
`else
  localparam int unused_starve_limit = STARVE_LIMIT;

  assign mem_ready = !rst;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random traffic
// against a cycle-level reference of the arbitration and RAM contents.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int ADDR_W       = 16;
  localparam int STARVE_LIMIT = 4;
  localparam int NWORDS       = 1 << (ADDR_W - 2);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [15:0]       imem_addr = '0;
  logic              imem_oe = 1'b0;
  logic [31:0]       imem_rdata;
  logic              imem_valid;
  logic [31:0]       mem_addr = '0;
  logic [3:0]        mem_oe = '0;
  logic [31:0]       mem_wdata = '0;
  logic [3:0]        mem_we = '0;
  logic [31:0]       mem_rdata;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-3:0] ram_addr;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = '0;
  logic              misalign;

  mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_oe(imem_oe), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .mem_addr(mem_addr), .mem_oe(mem_oe), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .ram_addr(ram_addr), .ram_en(ram_en), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [13:0] w);
    if (w == 14'h0040) return 32'h0000_0013;
    return {w ^ 14'h2a5c, 2'b01, w, 2'b10};
  endfunction

  // The RAM the arbiter drives.
  logic [31:0] ram [NWORDS];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NWORDS; i++) ram[i] <= init_word(14'(i));
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= ram[ram_addr];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [NWORDS];
  int          checks = 0;
  int          failures = 0;
  bit          m_park_v;
  logic [13:0] m_park_w;
  int          m_wait;
  bit          e_iv, e_dv, e_mis, prev_ready;
  logic [31:0] e_ival, e_dval, e_dmask;

  function automatic logic [31:0] bytemask(input logic [3:0] lanes);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = lanes[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic [31:0] load_mask(input logic [3:0] oe);
    int nbytes;
    nbytes = 0;
    for (int b = 0; b < 4; b++) if (oe[b]) nbytes++;
    return (nbytes >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
  endfunction

  function automatic bit model_ready();
`ifdef MEMARB_STARVE_GUARD_EN
    return !(m_park_v && m_wait == STARVE_LIMIT - 1);
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit ioe, input logic [15:0] iaddr, input logic [3:0] oe,
                        input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    imem_oe   = ioe;
    imem_addr = iaddr;
    mem_oe    = oe;
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = wdata;
  endtask

  task automatic model_clear();
    m_park_v = 1'b0; m_park_w = '0; m_wait = 0;
    e_iv = 1'b0; e_dv = 1'b0; e_mis = 1'b0; prev_ready = 1'b1;
    e_ival = '0; e_dval = '0; e_dmask = 32'hFFFF_FFFF;
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = init_word(14'(i));
  endtask

  // Check one cycle against the model, then advance to just after the next edge.
  task automatic step();
    bit          dreq, st, exp_en, ready_exp, n_iv, n_dv, mis_next;
    logic [1:0]  off;
    logic [13:0] dw, iw, exp_w;
    logic [3:0]  exp_we;
    logic [31:0] sh_wdata, n_ival, n_dval, n_dmask;
    #1;
    dreq = (mem_oe != 4'b0000);
    st   = (mem_we != 4'b0000);
    off  = mem_addr[1:0];
    dw   = mem_addr[15:2];
    iw   = imem_addr[15:2];
    ready_exp = model_ready();
    sh_wdata  = mem_wdata << (8 * off);
    exp_en = 1'b1; exp_we = 4'b0000; exp_w = '0;
    if (dreq) begin
      exp_w  = dw;
      exp_we = 4'(32'(mem_we) << off);
    end else if (imem_oe) exp_w = iw;
    else if (m_park_v)    exp_w = m_park_w;
    else                  exp_en = 1'b0;

    chk("ram_en", 32'(ram_en), 32'(exp_en));
    if (exp_en) chk("ram_addr", 32'(ram_addr), 32'(exp_w));
    chk("ram_we", 32'(ram_we), 32'(exp_we));
    if (exp_we != 4'b0000)
      chk("ram_wdata", ram_wdata & bytemask(exp_we), sh_wdata & bytemask(exp_we));
    chk("imem_valid", 32'(imem_valid), 32'(e_iv));
    chk("imem_rdata", imem_rdata, e_ival);
    chk("mem_valid", 32'(mem_valid), 32'(e_dv));
    chk("mem_rdata", mem_rdata & e_dmask, e_dval & e_dmask);
    chk("mem_ready", 32'(mem_ready), 32'(ready_exp));
    chk("misalign", 32'(misalign), 32'(e_mis));

    n_iv = 1'b0; n_dv = 1'b0; mis_next = 1'b0;
    n_ival = e_ival; n_dval = e_dval; n_dmask = e_dmask;
    if (dreq) begin
      if (!st) begin
        n_dv    = 1'b1;
        n_dval  = ref_mem[dw] >> (8 * off);
        n_dmask = load_mask(mem_oe);
      end
      for (int b = 0; b < 4; b++)
        if (exp_we[b]) ref_mem[dw][8*b +: 8] = sh_wdata[8*b +: 8];
      if ((32'(mem_oe) << off) > 32'd15) mis_next = 1'b1;
    end else if (exp_en) begin
      n_iv   = 1'b1;
      n_ival = ref_mem[exp_w];
    end
    m_wait = (dreq && m_park_v) ? m_wait + 1 : 0;
    if (dreq && imem_oe) begin
      m_park_v = 1'b1;
      m_park_w = iw;
    end else if (!dreq) m_park_v = 1'b0;

    @(posedge clk);
    #1;
    e_iv = n_iv; e_ival = n_ival;
    e_dv = n_dv; e_dval = n_dval; e_dmask = n_dmask;
    e_mis = e_mis | mis_next;
    prev_ready = ready_exp;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      set_in(1'b0, 16'h0, 4'h0, 4'h0, 32'h0, 32'h0);
      step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b0, 16'h0, 4'h0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("rst_imem_valid", 32'(imem_valid), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_rdata", imem_rdata, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_valid_pair", {30'd0, imem_valid, mem_valid}, 32'd0);
    model_clear();
    rst = 1'b0;
  endtask

  initial begin
    int lows, ivs;
    do_reset();

    // Isolated fetch from 0x0100 (word 0x40 holds 0x13)
    set_in(1'b1, 16'h0100, 4'h0, 4'h0, 32'h0, 32'h0);
    #1 chk("iso_ram_addr", 32'(ram_addr), 32'h40);
    step();
    chk("iso_valid", 32'(imem_valid), 32'd1);
    chk("iso_rdata", imem_rdata, 32'h0000_0013);
    idle(5);
    chk("iso_hold", imem_rdata, 32'h0000_0013);

    // Collision: fetch 0x0104 with LW 0x2000
    set_in(1'b1, 16'h0104, LANE_W, 4'h0, 32'h0000_2000, 32'h0);
    step();
    chk("col_mem_valid", 32'(mem_valid), 32'd1);
    chk("col_mem_rdata", mem_rdata, init_word(14'h800));
    set_in(1'b0, 16'h0, 4'h0, 4'h0, 32'h0, 32'h0);
    step();
    chk("col_imem_valid", 32'(imem_valid), 32'd1);
    chk("col_imem_rdata", imem_rdata, init_word(14'h041));

    // Byte lanes: SB, LBU, then misaligned LH
    set_in(1'b0, 16'h0, LANE_B, LANE_B, 32'h0000_2003, 32'h0000_00AB);
    #1;
    chk("sb_ram_we", 32'(ram_we), 32'b1000);
    chk("sb_byte", {24'd0, ram_wdata[31:24]}, 32'h0000_00AB);
    step();
    set_in(1'b0, 16'h0, LANE_B, 4'h0, 32'h0000_2003, 32'h0);
    step();
    chk("lbu_byte", {24'd0, mem_rdata[7:0]}, 32'h0000_00AB);
    set_in(1'b0, 16'h0, LANE_H, 4'h0, 32'h0000_2003, 32'h0);
    step();
    chk("lh_misalign", 32'(misalign), 32'd1);
    idle(3);
    chk("misalign_sticky", 32'(misalign), 32'd1);

    // Flush: parked 0x0108 superseded by 0x0200
    ivs = 0;
    set_in(1'b1, 16'h0108, LANE_W, 4'h0, 32'h0000_2004, 32'h0);
    step();
    if (imem_valid) ivs++;
    set_in(1'b1, 16'h0200, 4'h0, 4'h0, 32'h0, 32'h0);
    step();
    if (imem_valid) ivs++;
    for (int k = 0; k < 3; k++) begin
      idle(1);
      if (imem_valid) begin
        ivs++;
        chk("flush_rdata", imem_rdata, init_word(14'h080));
      end
    end
    chk("flush_count", 32'(ivs), 32'd1);

    // Starvation: parked fetch under continuous loads
    set_in(1'b1, 16'h010C, LANE_W, 4'h0, 32'h0000_2000, 32'h0);
    step();
    lows = 0;
    for (int k = 0; k < 6; k++) begin
      if (prev_ready) set_in(1'b0, 16'h0, LANE_W, 4'h0, 32'h0000_2008, 32'h0);
      else            set_in(1'b0, 16'h0, 4'h0, 4'h0, 32'h0, 32'h0);
      #1;
      if (!mem_ready) lows++;
      step();
    end
`ifdef MEMARB_STARVE_GUARD_EN
    chk("starve_low_cycles", 32'(lows), 32'd1);
`else
    chk("starve_low_cycles", 32'(lows), 32'd0);
`endif
    idle(3);

    // Reset in the cycle after a load issues
    set_in(1'b0, 16'h0, LANE_W, 4'h0, 32'h0000_2004, 32'h0);
    step();
    do_reset();
    idle(2);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r, hi, wd;
      logic [3:0]  lanes;
      logic [1:0]  off;
      bit          ioe, dreq, st;
      r  = $urandom;
      hi = $urandom;
      wd = $urandom;
      ioe  = (r[1:0] == 2'b00);
      dreq = prev_ready && r[2];
      st   = r[3];
      case (r[5:4])
        2'd0:    lanes = LANE_B;
        2'd1:    lanes = LANE_H;
        default: lanes = LANE_W;
      endcase
      if (lanes == LANE_B)      off = r[7:6];
      else if (lanes == LANE_H) off = {r[6], 1'b0};
      else                      off = 2'b00;
      set_in(ioe, {6'b0, r[15:8], r[17:16]},
             dreq ? lanes : 4'h0, (dreq && st) ? lanes : 4'h0,
             {hi[31:16], 8'h20, r[23:18], off}, wd);
      step();
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
